// File: rtl/dmem_lane_ctrl.sv
// Byte-addressable data memory: four byte-lane banks, valid/ready requests, post-reset clear sweep.
// Build option DMEM_MISALIGN_SPLIT_EN: word-crossing accesses run as two beats instead of faulting.
module dmem_lane_ctrl #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_signext,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        init_done
);
  localparam int unsigned IDX_W = ADDR_WIDTH - 2;
  localparam int unsigned WORDS = 1 << IDX_W;

`ifdef DMEM_MISALIGN_SPLIT_EN
  typedef enum logic [1:0] {CLEAR, IDLE, SECOND} state_t;
`else
  typedef enum logic [1:0] {CLEAR, IDLE} state_t;
`endif

  state_t             state, state_nx;
  logic [IDX_W-1:0]   cnt, cnt_nx;
  logic               resp_valid_nx, resp_fault_nx, init_done_nx;
  logic [31:0]        resp_rdata_nx;
  logic [7:0]         bank [4][WORDS];

  logic [2:0]         req_nb;
  logic               req_cross;
  logic [1:0]         cur_off;
  logic [2:0]         cur_nb;
  logic [IDX_W-1:0]   cur_idx;
  logic               cur_beat2, cur_store, cur_signext;
  logic [31:0]        cur_wdata, cur_base;
  logic [3:0]         lo, hi, pos;
  logic [1:0]         kidx;
  logic [3:0][7:0]    rd, wr_bytes, mem_wd;
  logic [3:0]         lane_act, mem_we;
  logic [IDX_W-1:0]   mem_wa;
  logic [31:0]        asm_w, ext;
  logic               unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH];
  assign req_ready      = (state == IDLE);

`ifdef DMEM_MISALIGN_SPLIT_EN
  logic               pend_load;
  logic               pend_store, pend_signext;
  logic [1:0]         pend_off;
  logic [2:0]         pend_nb;
  logic [IDX_W-1:0]   pend_idx;
  logic [31:0]        pend_wdata, pend_bytes;
`endif

  always_comb begin
    unique case (req_size)
      2'b00:   req_nb = 3'd1;
      2'b01:   req_nb = 3'd2;
      default: req_nb = 3'd4;
    endcase
    req_cross = ({2'b00, req_addr[1:0]} + 4'(req_nb)) > 4'd4;
  end

  // Select the beat being executed: a fresh request, or the held tail of a crossing one.
  always_comb begin
    cur_off     = req_addr[1:0];
    cur_nb      = req_nb;
    cur_idx     = req_addr[ADDR_WIDTH-1:2];
    cur_beat2   = 1'b0;
    cur_store   = req_store;
    cur_signext = req_signext;
    cur_wdata   = req_wdata;
    cur_base    = '0;
`ifdef DMEM_MISALIGN_SPLIT_EN
    if (state == SECOND) begin
      cur_off     = pend_off;
      cur_nb      = pend_nb;
      cur_idx     = pend_idx;
      cur_beat2   = 1'b1;
      cur_store   = pend_store;
      cur_signext = pend_signext;
      cur_wdata   = pend_wdata;
      cur_base    = pend_bytes;
    end
`endif
  end

  // Per-lane decode: pos is the lane's byte offset from the first word, kidx its byte within the access.
  always_comb begin
    lo       = {2'b00, cur_off};
    hi       = lo + 4'(cur_nb);
    pos      = '0;
    kidx     = '0;
    asm_w    = cur_base;
    lane_act = '0;
    wr_bytes = '0;
    rd       = '0;
    for (int l = 0; l < 4; l++) begin
      rd[l] = bank[l][cur_idx];
      pos   = 4'(l) + (cur_beat2 ? 4'd4 : 4'd0);
      kidx  = 2'(pos - lo);
      if (pos >= lo && pos < hi) begin
        lane_act[l]               = 1'b1;
        asm_w[{kidx, 3'b000} +: 8] = rd[l];
        wr_bytes[l]               = cur_wdata[{kidx, 3'b000} +: 8];
      end
    end
    unique case (cur_nb)
      3'd1:    ext = {{24{cur_signext & asm_w[7]}}, asm_w[7:0]};
      3'd2:    ext = {{16{cur_signext & asm_w[15]}}, asm_w[15:0]};
      default: ext = asm_w;
    endcase
  end

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    init_done_nx  = init_done;
    resp_valid_nx = 1'b0;
    resp_fault_nx = 1'b0;
    resp_rdata_nx = '0;
    mem_we        = '0;
    mem_wa        = cur_idx;
    mem_wd        = wr_bytes;
`ifdef DMEM_MISALIGN_SPLIT_EN
    pend_load     = 1'b0;
`endif
    unique case (state)
      CLEAR: begin
        mem_we = 4'hf;
        mem_wa = cnt;
        mem_wd = '0;
        cnt_nx = cnt + IDX_W'(1);
        if (&cnt) begin
          state_nx     = IDLE;
          init_done_nx = 1'b1;
        end
      end
      IDLE: begin
        if (req_valid) begin
          if (req_size == 2'b11) begin
            resp_valid_nx = 1'b1;
            resp_fault_nx = 1'b1;
          end else if (req_cross) begin
`ifdef DMEM_MISALIGN_SPLIT_EN
            if (req_store) mem_we = lane_act;
            pend_load = 1'b1;
            state_nx  = SECOND;
`else
            resp_valid_nx = 1'b1;
            resp_fault_nx = 1'b1;
`endif
          end else begin
            resp_valid_nx = 1'b1;
            if (req_store) mem_we = lane_act;
            else           resp_rdata_nx = ext;
          end
        end
      end
`ifdef DMEM_MISALIGN_SPLIT_EN
      SECOND: begin
        resp_valid_nx = 1'b1;
        state_nx      = IDLE;
        if (cur_store) mem_we = lane_act;
        else           resp_rdata_nx = ext;
      end
`endif
      default: state_nx = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLEAR;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_rdata <= '0;
      init_done  <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      resp_valid <= resp_valid_nx;
      resp_fault <= resp_fault_nx;
      resp_rdata <= resp_rdata_nx;
      init_done  <= init_done_nx;
    end
  end

  // Banks are left untouched while reset is held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int l = 0; l < 4; l++) begin
        if (mem_we[l]) bank[l][mem_wa] <= mem_wd[l];
      end
    end
  end

`ifdef DMEM_MISALIGN_SPLIT_EN
  always_ff @(posedge clk) begin
    if (pend_load && !rst) begin
      pend_store   <= req_store;
      pend_signext <= req_signext;
      pend_off     <= req_addr[1:0];
      pend_nb      <= req_nb;
      pend_idx     <= cur_idx + IDX_W'(1);
      pend_wdata   <= req_wdata;
      pend_bytes   <= asm_w;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_lane_ctrl.sv
// Directed bench for dmem_lane_ctrl (ADDR_WIDTH = 10); follows DMEM_MISALIGN_SPLIT_EN for crossing cases.
module tb_dmem_lane_ctrl;
  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_signext;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        init_done;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] bb_addr [3];
  logic [31:0] bb_data [3];
  logic [31:0] r;
  logic        f;
  int          lat;
  int          n;

  dmem_lane_ctrl #(.ADDR_WIDTH(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_signext(req_signext), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid   = 1'b1;
    req_store   = st;
    req_size    = sz;
    req_signext = sx;
    req_addr    = a;
    req_wdata   = wd;
  endtask

  // Issue one request and wait (bounded) for its response pulse.
  task automatic access(input logic st, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rdata, output logic flt, output int l);
    drive(st, sz, sx, a, wd);
    @(posedge clk); #1;
    req_valid = 1'b0;
    l = 1;
    while (!resp_valid && l < 8) begin
      @(posedge clk); #1;
      l++;
    end
    rdata = resp_rdata;
    flt   = resp_fault;
  endtask

  task automatic ld(input string tag, input logic [1:0] sz, input logic sx,
                    input logic [31:0] a, input logic [31:0] exp, input int exp_lat);
    logic [31:0] rr;
    logic        ff;
    int          ll;
    access(1'b0, sz, sx, a, 32'h0, rr, ff, ll);
    chk({tag, "_data"}, rr, exp);
    chk({tag, "_lat"}, 32'(ll), 32'(exp_lat));
  endtask

  task automatic st(input string tag, input logic [1:0] sz, input logic [31:0] a,
                    input logic [31:0] wd);
    logic [31:0] rr;
    logic        ff;
    int          ll;
    access(1'b1, sz, 1'b0, a, wd, rr, ff, ll);
    chk({tag, "_flt"}, 32'(ff), 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00; req_signext = 1'b0;
    req_addr = '0; req_wdata = '0;
    bb_addr[0] = 32'h020; bb_data[0] = 32'hDEADBEEF;
    bb_addr[1] = 32'h024; bb_data[1] = 32'h01234567;
    bb_addr[2] = 32'h028; bb_data[2] = 32'hCAFEF00D;

    // Reset and clear sweep
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_rvalid", 32'(resp_valid), 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_fault", 32'(resp_fault), 32'h0);
    chk("rst_init", 32'(init_done), 32'h0);
    rst = 1'b0;
    for (int i = 1; i <= 256; i++) begin
      @(posedge clk); #1;
      if (i == 1 || i == 255) chk("sweep_busy", 32'(init_done), 32'h0);
      if (i == 256) begin
        chk("sweep_done", 32'(init_done), 32'h1);
        chk("sweep_ready", 32'(req_ready), 32'h1);
      end
    end
    ld("clr_3fc", 2'b10, 1'b0, 32'h3FC, 32'h0, 1);

    // Lane stores and extension
    access(1'b1, 2'b10, 1'b0, 32'h010, 32'h80FF7F01, r, f, lat);
    chk("st_rdata0", r, 32'h0);
    chk("st_lat", 32'(lat), 32'h1);
    ld("lb_011_sx", 2'b00, 1'b1, 32'h011, 32'h0000007F, 1);
    ld("lb_013_sx", 2'b00, 1'b1, 32'h013, 32'hFFFFFF80, 1);
    ld("lh_012_zx", 2'b01, 1'b0, 32'h012, 32'h000080FF, 1);
    ld("lh_011_zx", 2'b01, 1'b0, 32'hFFFF_F011, 32'h0000FF7F, 1);
    ld("lh_011_sx", 2'b01, 1'b1, 32'h011, 32'hFFFFFF7F, 1);
    st("sb_012", 2'b00, 32'h012, 32'h123456AB);
    ld("lw_010", 2'b10, 1'b1, 32'h010, 32'h80AB7F01, 1);

    // Back-to-back stores then loads
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b10, 1'b0, bb_addr[i], bb_data[i]);
      @(posedge clk); #1;
      chk("bb_st_rv", 32'(resp_valid), 32'h1);
      chk("bb_st_rdy", 32'(req_ready), 32'h1);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'b10, 1'b0, bb_addr[i], 32'h0);
      @(posedge clk); #1;
      chk("bb_ld_rv", 32'(resp_valid), 32'h1);
      chk("bb_ld_data", resp_rdata, bb_data[i]);
      chk("bb_ld_rdy", 32'(req_ready), 32'h1);
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("bb_idle_rv", 32'(resp_valid), 32'h0);
    chk("bb_idle_rd", resp_rdata, 32'h0);

    // Word-crossing store with wrap from the last word to word 0
    st("pre_3fc", 2'b10, 32'h3FC, 32'h99887766);
    st("pre_000", 2'b10, 32'h000, 32'h44332211);
    drive(1'b1, 2'b10, 1'b0, 32'h3FE, 32'hA1B2C3D4);
    @(posedge clk); #1;
    req_valid = 1'b0;
`ifdef DMEM_MISALIGN_SPLIT_EN
    chk("x_b1_ready", 32'(req_ready), 32'h0);
    chk("x_b1_rv", 32'(resp_valid), 32'h0);
    @(posedge clk); #1;
    chk("x_b2_rv", 32'(resp_valid), 32'h1);
    chk("x_b2_flt", 32'(resp_fault), 32'h0);
    chk("x_b2_ready", 32'(req_ready), 32'h1);
    ld("x_lb_001", 2'b00, 1'b0, 32'h001, 32'h000000A1, 1);
    ld("x_lh_3fe", 2'b01, 1'b0, 32'h3FE, 32'h0000C3D4, 1);
    ld("x_lw_3fc", 2'b10, 1'b0, 32'h3FC, 32'hC3D47766, 1);
    ld("x_lw_000", 2'b10, 1'b0, 32'h000, 32'h4433A1B2, 1);
    ld("x_lw_3fe", 2'b10, 1'b0, 32'h3FE, 32'hA1B2C3D4, 2);
    ld("x_lh_3ff", 2'b01, 1'b1, 32'h3FF, 32'hFFFFB2C3, 2);
`else
    chk("x_rv", 32'(resp_valid), 32'h1);
    chk("x_flt", 32'(resp_fault), 32'h1);
    chk("x_rdata", resp_rdata, 32'h0);
    chk("x_ready", 32'(req_ready), 32'h1);
    ld("x_lw_3fc", 2'b10, 1'b0, 32'h3FC, 32'h99887766, 1);
    ld("x_lw_000", 2'b10, 1'b0, 32'h000, 32'h44332211, 1);
    access(1'b0, 2'b10, 1'b0, 32'h3FE, 32'h0, r, f, lat);
    chk("x_ld_flt", 32'(f), 32'h1);
    chk("x_ld_rdata", r, 32'h0);
`endif

    // Invalid size
    st("pre_040", 2'b10, 32'h040, 32'h5A5A5A5A);
    access(1'b0, 2'b11, 1'b0, 32'h040, 32'h0, r, f, lat);
    chk("inv_ld_flt", 32'(f), 32'h1);
    chk("inv_ld_rdata", r, 32'h0);
    chk("inv_ld_lat", 32'(lat), 32'h1);
    access(1'b1, 2'b11, 1'b0, 32'h040, 32'hFFFFFFFF, r, f, lat);
    chk("inv_st_flt", 32'(f), 32'h1);
    ld("inv_lw_040", 2'b10, 1'b0, 32'h040, 32'h5A5A5A5A, 1);

    // Reset in the cycle after accepting a crossing store
    drive(1'b1, 2'b10, 1'b0, 32'h3FE, 32'h0BADF00D);
    @(posedge clk); #1;
    req_valid = 1'b0;
`ifdef DMEM_MISALIGN_SPLIT_EN
    chk("mr_ready", 32'(req_ready), 32'h0);
`endif
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mr_rv", 32'(resp_valid), 32'h0);
    chk("mr_init", 32'(init_done), 32'h0);
    chk("mr_rdy", 32'(req_ready), 32'h0);
    rst = 1'b0;
    n = 0;
    while (!init_done && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mr_done", 32'(init_done), 32'h1);
    chk("mr_edges", 32'(n), 32'd256);
    chk("mr_rv2", 32'(resp_valid), 32'h0);
    ld("mr_lw_3fc", 2'b10, 1'b0, 32'h3FC, 32'h0, 1);
    ld("mr_lw_000", 2'b10, 1'b0, 32'h000, 32'h0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dmem_lane_ctrl.md
# dmem_lane_ctrl

Parametrised byte-addressable data memory for the CPU load/store stage, the successor to the fixed 1 KB data memory. Storage is four byte-lane banks of 2^(ADDR_WIDTH-2) words. Accesses use a valid/ready request channel and a single-cycle response pulse. Word-crossing accesses run as a two-beat sequence, and the block clears itself after reset with a sequential sweep.

## Interface
Parameters:
- ADDR_WIDTH, 10, byte-address bits used; capacity 2^ADDR_WIDTH bytes; legal range 3..16.
- WORDS, 2^(ADDR_WIDTH-2), derived (localparam): words per bank.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_store  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 invalid.
- req_signext  in  1  loads: 1 sign-extends, 0 zero-extends; ignored for word and store.
- req_addr  in  32  byte address; only [ADDR_WIDTH-1:0] used; upper bits ignored.
- req_wdata  in  32  store data, little-endian, LSBs valid for byte/half.
- resp_valid  out  1  one-cycle pulse per accepted request.
- resp_rdata  out  32  load result; 0 for stores, faults and whenever resp_valid = 0.
- resp_fault  out  1  qualifies resp_valid; 1 = request rejected, memory unchanged.
- init_done  out  1  1 once the post-reset clear sweep completes.

## Operation
- Byte order: little-endian. Byte at address A lives in bank A[1:0], word index A[ADDR_WIDTH-1:2].
- A request is accepted on a rising edge with req_valid && req_ready. req_ready = (state == IDLE), independent of req_valid.
- FSM states:
  - CLEAR: while rst = 1, counter = 0, no writes. On each edge with rst = 0, zero all four lanes of word[counter] and increment. After word WORDS-1 is written, go to IDLE and set init_done = 1.
  - IDLE: accept requests. A non-crossing access completes in one beat and stays in IDLE. A crossing access goes to SECOND.
  - SECOND: access the remaining bytes at word index + 1. Return to IDLE.
- Crossing condition: addr[1:0] + bytes > 4, where bytes is 1, 2 or 4. Affected cases: half at offset 3; word at offsets 1, 2, 3.
- Non-crossing misaligned access (half at offset 1) is legal and single-beat.
- Word index + 1 wraps modulo WORDS, so the last word continues into word 0.
- Stores write only the addressed byte lanes; other lanes keep their contents.
- Loads assemble bytes in address order, then apply zero- or sign-extension from the top loaded byte for byte/half.
- req_size = 11 → fault response, no write, resp_rdata = 0.
- rst asserted in any state → CLEAR with counter = 0, resp_valid = 0, init_done = 0, and any pending second beat dropped with no response. Bank contents are not touched while rst = 1.

## Timing
- Reset values: req_ready 0, resp_valid 0, resp_rdata 0, resp_fault 0, init_done 0.
- Clear sweep: init_done rises after the WORDS-th edge with rst = 0 (256 edges at ADDR_WIDTH = 10). req_ready rises on the same edge.
- Single-beat access accepted at edge T: banks read/written at T, resp_valid high for cycle T..T+1.
- Throughput: one single-beat request per cycle, back-to-back.
- Crossing access accepted at T:
  - first beat at edge T; req_ready = 0 during the following cycle;
  - second beat at edge T+1; resp_valid high in cycle T+1..T+2;
  - req_ready returns to 1 in that same cycle.
- Read-after-write: a load accepted at the edge after a store to the same bytes returns the stored data.
- Within a crossing store, beat 1 writes low-address bytes and beat 2 writes the rest; both complete before resp_valid.
- Responses cannot be back-pressured.

## Configuration
- DMEM_MISALIGN_SPLIT_EN defined: crossing accesses execute as two beats, as above.
- Undefined: crossing accesses are rejected. The response is single-cycle (resp_valid at T+1) with resp_fault = 1 and resp_rdata = 0. No bank is written, and the SECOND state is not built.

## Test plan
- Reset then idle: hold rst for 3 cycles, then release → init_done = 0 for 255 edges and 1 after edge 256. A word load at 0x3FC returns 0x00000000.
- Lane stores and extension:
  - store word 0x80FF7F01 at 0x010;
  - load byte 0x011 with signext = 1 → 0x0000007F;
  - load byte 0x013 with signext = 1 → 0xFFFFFF80;
  - load half 0x012 with signext = 0 → 0x000080FF.
- Back-to-back: stores to 0x020, 0x024 and 0x028 in consecutive cycles, then three loads → three responses on consecutive cycles with the correct data, req_ready held at 1.
- Crossing with wrap (DMEM_MISALIGN_SPLIT_EN): store word 0xA1B2C3D4 at 0x3FE →
  - req_ready low for one cycle, response at T+2;
  - load byte 0x001 → 0x000000A1, load half 0x3FE → 0x0000C3D4.
  - Without the macro: resp_fault = 1 at T+1, and 0x3FE/0x000 are unchanged.
- Invalid size: load with req_size = 11 at 0x040 → resp_fault = 1, resp_rdata = 0, memory unchanged.
- Reset mid-sequence: assert rst in the SECOND cycle of a crossing store → no resp_valid, init_done drops, and after the sweep the target words read 0.
